// File: rtl/mux_nx1_arb_if.sv
// mux_nx1_arb_if -- handshake/bus bundle for the N:1 mux/arbiter.
//   Upstream side : in_data (NUM_IN packed words), in_valid, in_ready
//   Control       : mode (0 = explicit select, 1 = round-robin), sel
//   Downstream    : out_data, out_valid, out_src, out_ready
// Modport "master" is the environment that feeds channels and consumes the
// output; modport "slave" is the mux itself.
interface mux_nx1_arb_if #(
   parameter int WIDTH  = 16,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = 2
);
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [NUM_IN-1:0]       in_valid;
   logic [NUM_IN-1:0]       in_ready;
   logic                    mode;
   logic [SEL_W-1:0]        sel;
   logic [WIDTH-1:0]        out_data;
   logic                    out_valid;
   logic [SEL_W-1:0]        out_src;
   logic                    out_ready;

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_valid, out_src
   );

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_valid, out_src
   );
endinterface

// File: rtl/mux_nx1_arb.sv
// mux_nx1_arb -- NUM_IN-to-1 multiplexer with explicit-select or round-robin
// arbitration feeding a single-entry registered output stage.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (clears output register and rr_ptr)
//   bus  : mux_nx1_arb_if.slave -- channel inputs/ready, mode/sel controls,
//          registered out_data/out_valid/out_src with out_ready handshake.
// A word moves from channel g into the output register whenever g is granted
// and the register is empty or being drained in the same cycle.
module mux_nx1_arb #(
   parameter int WIDTH  = 16,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = 2
) (
   input  logic         clk,
   input  logic         rst,
   mux_nx1_arb_if.slave bus
);

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic [SEL_W-1:0] out_src_q, out_src_d;
   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

   logic             grant_vld;
   logic [SEL_W-1:0] grant_idx;
   logic [WIDTH-1:0] grant_data;
   logic             can_accept;
   logic             xfer;

   assign can_accept = !out_valid_q || bus.out_ready;
   assign xfer       = grant_vld && can_accept;

   always_comb begin : grant_sel
      int cand;
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = 0;
      if (!bus.mode) begin
         // An out-of-range sel matches no channel, so it yields no grant.
         for (int i = 0; i < NUM_IN; i++) begin
            if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
               grant_vld = 1'b1;
               grant_idx = SEL_W'(i);
            end
         end
      end else begin
         // Walk offsets from the far end down so the valid channel nearest
         // to rr_ptr (in upward, wrapping order) is assigned last and wins.
         for (int k = NUM_IN - 1; k >= 0; k--) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_IN) cand = cand - NUM_IN;
            if (bus.in_valid[cand]) begin
               grant_vld = 1'b1;
               grant_idx = SEL_W'(cand);
            end
         end
      end
   end

   always_comb begin : data_mux
      grant_data = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (grant_idx == SEL_W'(i)) grant_data = bus.in_data[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin : ready_gen
      bus.in_ready = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (xfer && !rst && grant_idx == SEL_W'(i)) bus.in_ready[i] = 1'b1;
      end
   end

   always_comb begin : next_state
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_src_d   = out_src_q;
      rr_ptr_d    = rr_ptr_q;
      if (xfer) begin
         // A load while draining keeps out_valid high: one word per cycle.
         out_data_d  = grant_data;
         out_valid_d = 1'b1;
         out_src_d   = grant_idx;
         if (bus.mode) begin
            rr_ptr_d = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + SEL_W'(1);
         end
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Output register stage
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_src_q   <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_src_q   <= out_src_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_src   = out_src_q;

endmodule

// File: doc/mux_nx1_arb.md
MUX_NX1_ARB -- requirements
Module: mux_nx1_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the data width per channel in bits (WIDTH >= 1).
REQ-002 The block SHALL have parameter NUM_IN, default 4, meaning the number of input channels (2..16).
REQ-003 The block SHALL have parameter SEL_W, default 2, meaning the select and source-index width; it equals ceil(log2(NUM_IN)).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, as the following two port lines state.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  input  NUM_IN  channel i offers data.
REQ-009 in_ready  output  NUM_IN  channel i transfer accepted this cycle (combinational).
REQ-010 mode  input  1  0 = explicit select; 1 = round-robin arbitration.
REQ-011 sel  input  SEL_W  channel index used when mode=0.
REQ-012 out_data  output  WIDTH  registered selected data.
REQ-013 out_valid  output  1  out_data holds an undelivered word.
REQ-014 out_src  output  SEL_W  index of the channel that supplied out_data.
REQ-015 out_ready  input  1  downstream accepts out_data this cycle.

Function
REQ-016 The block SHALL hold a single-entry output register; can_accept = !out_valid || out_ready.
REQ-017 In mode 0, the block SHALL set the grant to channel sel when sel < NUM_IN and in_valid[sel]=1; otherwise there SHALL be no grant.
REQ-018 In mode 1, the block SHALL grant the first channel with in_valid=1 when scanning upward from rr_ptr with wrap past NUM_IN-1 to 0; when no channel is valid there SHALL be no grant.
REQ-019 in_ready[g] SHALL be asserted only when g is the granted channel and can_accept=1; at most one bit of in_ready SHALL be high, and all bits SHALL be low when there is no grant.
REQ-020 On a transfer, which is a grant with can_accept=1, the block SHALL at the next edge set out_data to in_data[g], set out_src to g, and set out_valid to 1, giving a latency of 1 cycle.
REQ-021 When out_valid=1, out_ready=1 and there is no transfer, the block SHALL clear out_valid at the next edge; out_data and out_src SHALL keep their values.
REQ-022 When out_valid=1 and out_ready=0, out_data, out_src and out_valid SHALL stay stable, and in_ready SHALL be all-zero.
REQ-023 A simultaneous drain (out_valid && out_ready) and new transfer in the same cycle SHALL load the new word with out_valid staying 1, giving full throughput of 1 word per cycle.
REQ-024 rr_ptr SHALL update only on a mode-1 transfer, becoming (g+1) mod NUM_IN; it SHALL keep its value during mode-0 operation and while idle.
REQ-025 A change of mode or sel SHALL affect only grants from the cycle it is applied; a word already held in the output register SHALL be unaffected.
REQ-026 The block SHALL hold no data other than the output register, and SHALL not drop, duplicate or reorder words.

Reset
REQ-027 When rst=1 at a rising edge, the block SHALL set out_valid=0, out_data=0, out_src=0 and rr_ptr=0, regardless of any transfer in progress.
REQ-028 While rst=1, in_ready SHALL be all-zero.
REQ-029 A word held in the output register when reset is applied SHALL be discarded and not delivered.
REQ-030 The first mode-1 grant after reset SHALL start its scan at channel 0.

Verification
REQ-031 Mode 0 select: WIDTH=16, NUM_IN=4, in_data channels {0x0000,0xFFFF,0x1234,0xABCD}, all valid, out_ready=1, sel stepping 0..3 -> out_data 0x0000, 0xFFFF, 0x1234, 0xABCD with out_src 0..3, each 1 cycle after its sel value.
REQ-032 Back-pressure: mode 0, sel=2, out_ready=0 for 3 cycles after the first load -> out_data=0x1234 stable, out_valid=1, in_ready=0000; after out_ready=1, the next word loads without a bubble.
REQ-033 Round-robin: mode 1, all four channels valid, out_ready=1 -> out_src sequence 0,1,2,3,0; with only channels 1 and 3 valid -> out_src sequence 1,3,1,3.
REQ-034 Pointer retention: in mode 1, grant channel 2, switch to mode 0 for 5 transfers on sel=0, return to mode 1 with all channels valid -> first grant is channel 3.
REQ-035 Reset mid-operation: out_valid=1 with out_ready=0, then assert rst for 1 cycle -> out_valid=0, out_data=0x0000, out_src=0; the first mode-1 grant afterwards is channel 0.
REQ-036 Invalid select: NUM_IN=3, SEL_W=2, mode 0, sel=3 -> in_ready=000 and out_valid stays 0.
